// File: rtl/reg_wr_pkg.sv
// +----------------------------------------------------------------------+
// | reg_wr_pkg : shared constants and types for the register write arbiter|
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package reg_wr_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int ADDR_W_DFLT = 5;
  localparam int CNT_W_DFLT  = 16;

  // Tie-break owner: which requester wins when both are valid.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_M = 1'b1
  } prio_e;

  localparam int REG_ZERO = 0;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// +----------------------------------------------------------------------+
// | rr_arb2  : two-way round-robin grant with freeze input                |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import reg_wr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] rdy,
  output logic [1:0] gnt
);

  prio_e r_prio;
  prio_e w_prio_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio <= PRIO_A;
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

  // Ready does not depend on the requester's own valid, only on the rival.
  always_comb begin
    rdy        = 2'b00;
    w_prio_nxt = r_prio;
    if (!hold) begin
      rdy[0] = !req[1] || (r_prio == PRIO_A);
      rdy[1] = !req[0] || (r_prio == PRIO_M);
    end
    gnt = req & rdy;
    if (gnt[0]) begin
      w_prio_nxt = PRIO_M;
    end else if (gnt[1]) begin
      w_prio_nxt = PRIO_A;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_wr_arbiter.sv
// +----------------------------------------------------------------------+
// | reg_wr_arbiter : shares the register bank write port between the ALU  |
// |                  and load writeback paths; FORWARD_EN adds a bypass   |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_wr_arbiter
  import reg_wr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int CNT_W  = CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [CNT_W-1:0]  stall_cnt
`ifdef FORWARD_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rf_r1,
  input  logic [DATA_W-1:0] rf_r2,
  output logic [DATA_W-1:0] r1_fwd,
  output logic [DATA_W-1:0] r2_fwd
`endif
);

  localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(REG_ZERO);

  logic [1:0]        w_rdy;
  logic [1:0]        w_gnt;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_stall;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_stall;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .req  ({m_valid, a_valid}),
    .rdy  (w_rdy),
    .gnt  (w_gnt)
  );

  assign a_ready    = w_rdy[0];
  assign m_ready    = w_rdy[1];
  assign w_sel_addr = w_gnt[1] ? m_addr : a_addr;
  assign w_sel_data = w_gnt[1] ? m_data : a_data;
  assign w_stall    = (a_valid && !w_rdy[0]) || (m_valid && !w_rdy[1]);

  // x0 writes are consumed but never reach the bank; address/data hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_stall <= '0;
    end else begin
      r_we <= 1'b0;
      if ((|w_gnt) && (w_sel_addr != C_ZERO)) begin
        r_we   <= 1'b1;
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
      end
      if (w_stall && (r_stall != '1)) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

  assign rf_we     = r_we;
  assign rf_addr   = r_addr;
  assign rf_data   = r_data;
  assign stall_cnt = r_stall;

`ifdef FORWARD_EN
  assign r1_fwd = (r_we && (r_addr != C_ZERO) && (r_addr == rd_addr1)) ? r_data : rf_r1;
  assign r2_fwd = (r_we && (r_addr != C_ZERO) && (r_addr == rd_addr2)) ? r_data : rf_r2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_wr_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_reg_wr_arbiter : vector table, corner sequences and random traffic |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_wr_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hold = 1'b0;
  logic          a_valid = 1'b0, m_valid = 1'b0;
  logic          a_ready, m_ready;
  logic [AW-1:0] a_addr = '0, m_addr = '0;
  logic [DW-1:0] a_data = '0, m_data = '0;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [CW-1:0] stall_cnt;

  logic [DW-1:0] bank_dut [32] = '{default: '0};

`ifdef FORWARD_EN
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0;
  logic [DW-1:0] rf_r1, rf_r2, r1_fwd, r2_fwd;
  logic [DW-1:0] s_r1, s_r2;
  assign rf_r1 = bank_dut[rd_addr1];
  assign rf_r2 = bank_dut[rd_addr2];
`endif

  reg_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .stall_cnt (stall_cnt)
`ifdef FORWARD_EN
    ,
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rf_r1     (rf_r1),
    .rf_r2     (rf_r2),
    .r1_fwd    (r1_fwd),
    .r2_fwd    (r2_fwd)
`endif
  );

  always #5 clk = ~clk;

  // Register bank driven by the DUT's write port.
  always @(posedge clk) begin
    if (rf_we) bank_dut[rf_addr] <= rf_data;
  end

  // Reference model: owed tie-break, expected write register, stall count, bank.
  bit            owed_m;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int            e_stall;
  logic [DW-1:0] mbank [32] = '{default: '0};

  int checks = 0;
  int errors = 0;
  bit s_ar, s_mr, s_ago, s_mgo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    owed_m  = 1'b0;
    e_we    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    e_stall = 0;
  endtask

  function automatic logic [DW-1:0] fwd_exp(input logic [AW-1:0] ra);
    if (e_we && e_addr != 0 && e_addr == ra) return e_data;
    return mbank[ra];
  endfunction

  // One cycle: called just after an edge with inputs already applied.
  task automatic step();
    bit ear, emr, stalled;
    #4;
    ear = !hold && (!m_valid || !owed_m);
    emr = !hold && (!a_valid || owed_m);
    s_ar = a_ready;
    s_mr = m_ready;
    chk("a_ready", 64'(a_ready), 64'(ear));
    chk("m_ready", 64'(m_ready), 64'(emr));
`ifdef FORWARD_EN
    s_r1 = r1_fwd;
    s_r2 = r2_fwd;
    chk("r1_fwd", 64'(r1_fwd), 64'(fwd_exp(rd_addr1)));
    chk("r2_fwd", 64'(r2_fwd), 64'(fwd_exp(rd_addr2)));
`endif
    s_ago   = a_valid && ear;
    s_mgo   = m_valid && emr;
    stalled = (a_valid && !ear) || (m_valid && !emr);
    @(posedge clk);
    if (e_we) mbank[e_addr] = e_data;
    if (stalled && e_stall < SAT) e_stall++;
    e_we = 1'b0;
    if (s_ago || s_mgo) begin
      owed_m = s_ago;
      if ((s_ago ? a_addr : m_addr) != 0) begin
        e_we   = 1'b1;
        e_addr = s_ago ? a_addr : m_addr;
        e_data = s_ago ? a_data : m_data;
      end
    end
    #1;
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("rf_addr", 64'(rf_addr), 64'(e_addr));
    chk("rf_data", 64'(rf_data), 64'(e_data));
    chk("stall_cnt", 64'(stall_cnt), 64'(e_stall));
  endtask

  typedef struct {
    logic          hold;
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          ear;
    logic          emr;
    logic          ewe;
    int            est;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b1, 1};
    tbl[1]  = '{1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b1, 2};
    tbl[2]  = '{1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b1, 3};
    tbl[3]  = '{1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b1, 4};
    tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 4};
    tbl[5]  = '{1'b0, 1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 4};
    tbl[6]  = '{1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 4};
    tbl[7]  = '{1'b1, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b0, 5};
    tbl[8]  = '{1'b1, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b0, 6};
    tbl[9]  = '{1'b1, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b0, 7};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h33, 1'b0, 1'b1, 1'b1, 7};
    tbl[11] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 7};

    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_rf_addr", 64'(rf_addr), 64'(0));
    chk("rst_rf_data", 64'(rf_data), 64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      hold = tbl[i].hold;
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      m_valid = tbl[i].mv; m_addr = tbl[i].ma; m_data = tbl[i].md;
      step();
      chk($sformatf("tbl%0d_a_ready", i), 64'(s_ar), 64'(tbl[i].ear));
      chk($sformatf("tbl%0d_m_ready", i), 64'(s_mr), 64'(tbl[i].emr));
      chk($sformatf("tbl%0d_rf_we", i), 64'(rf_we), 64'(tbl[i].ewe));
      chk($sformatf("tbl%0d_stall", i), 64'(stall_cnt), 64'(tbl[i].est));
    end
    chk("bank_x1", 64'(bank_dut[1]), 64'(32'h11));
    chk("bank_x2", 64'(bank_dut[2]), 64'(32'h22));
    chk("bank_x3", 64'(bank_dut[3]), 64'(32'h33));
    chk("bank_x5", 64'(bank_dut[5]), 64'(32'hAA));
    chk("bank_x0", 64'(bank_dut[0]), 64'(0));

    // Asynchronous reset in the cycle after a grant.
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    step();
    a_valid = 1'b0;
    #2 rst = 1'b0;
    mdl_reset();
    #1;
    chk("async_rst_we", 64'(rf_we), 64'(0));
    chk("async_rst_addr", 64'(rf_addr), 64'(0));
    chk("async_rst_stall", 64'(stall_cnt), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h10;
    m_valid = 1'b1; m_addr = 5'd11; m_data = 32'h11;
    step();
    chk("prio_after_rst_a", 64'(s_ar), 64'(1));
    chk("prio_after_rst_m", 64'(s_mr), 64'(0));
    a_valid = 1'b0;
    step();
    m_valid = 1'b0;
    step();
    chk("bank_x9_lost", 64'(bank_dut[9]), 64'(0));

`ifdef FORWARD_EN
    rd_addr1 = 5'd7; rd_addr2 = 5'd3;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h1234_5678;
    step();
    a_valid = 1'b0;
    step();
    chk("fwd_inflight", 64'(s_r1), 64'(32'h1234_5678));
    chk("fwd_r2_nobypass", 64'(s_r2), 64'(32'h33));
    step();
    chk("fwd_from_bank", 64'(s_r1), 64'(32'h1234_5678));
    chk("bank_x7", 64'(bank_dut[7]), 64'(32'h1234_5678));
`endif

    // Stall counter saturation under hold.
    hold = 1'b1; a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h44;
    repeat (20) step();
    chk("stall_sat", 64'(stall_cnt), 64'(SAT));
    hold = 1'b0;
    step();
    chk("stall_sat_hold", 64'(stall_cnt), 64'(SAT));
    a_valid = 1'b0;
    step();

    // Random traffic with requests held until accepted.
    s_ago = 1'b1; s_mgo = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 rst = 1'b0;
        mdl_reset();
        a_valid = 1'b0; m_valid = 1'b0;
        #1;
        chk("rand_rst_we", 64'(rf_we), 64'(0));
        chk("rand_rst_stall", 64'(stall_cnt), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
      end
      if (!a_valid || s_ago) begin
        a_valid = ($urandom % 3) != 0;
        a_addr  = AW'($urandom % 8);
        a_data  = $urandom;
      end
      if (!m_valid || s_mgo) begin
        m_valid = ($urandom % 3) != 0;
        m_addr  = AW'($urandom % 8);
        m_data  = $urandom;
      end
      hold = ($urandom % 8) == 0;
`ifdef FORWARD_EN
      rd_addr1 = AW'($urandom % 8);
      rd_addr2 = AW'($urandom % 8);
`endif
      step();
    end
    hold = 1'b0; a_valid = 1'b0; m_valid = 1'b0;
    step();
    step();
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("rand_bank_x%0d", r), 64'(bank_dut[r]), 64'(mbank[r]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Write-port arbiter for `Banco_de_Registros`, whose single write port (we, Addrs3, Data) is shared between the ALU writeback path and the load-unit writeback path. It grants one requester per cycle with two-way round-robin, registers the winning write into the register file, and drops writes to x0. It also keeps a saturating count of stall cycles. Optionally it bypasses the in-flight write onto the register file read outputs. It sits between the execute/memory stages and the register bank.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- hold  in  1  pipeline freeze; no grants while high
- a_valid / a_ready  in / out  1 / 1  ALU writeback handshake
- a_addr  in  ADDR_W  ALU destination register
- a_data  in  DATA_W  ALU result
- m_valid / m_ready  in / out  1 / 1  load writeback handshake
- m_addr  in  ADDR_W  load destination register
- m_data  in  DATA_W  load result
- rf_we  out  1  to register bank `we`
- rf_addr  out  ADDR_W  to register bank `Addrs3`
- rf_data  out  DATA_W  to register bank `Data`
- stall_cnt  out  CNT_W  cycles in which a valid request was not accepted (saturating)
- rd_addr1 / rd_addr2  in  ADDR_W  read addresses driven to `Addrs1` / `Addrs2` (FORWARD_EN only)
- rf_r1 / rf_r2  in  DATA_W  `R1_out` / `R2_out` from the register bank (FORWARD_EN only)
- r1_fwd / r2_fwd  out  DATA_W  bypassed read data (FORWARD_EN only)

## Operation
- The priority bit `prio` selects which requester wins a tie: 0 favours A, 1 favours M. Reset value is 0.
- Ready logic is combinational:
  - a_ready = !hold && (!m_valid || prio==0)
  - m_ready = !hold && (!a_valid || prio==1)
- A transfer occurs when valid && ready. At most one transfer happens per cycle.
- After a transfer, `prio` points to the requester that was not granted. With no transfer, `prio` holds its value.
- Write accepted with addr != 0: on the next edge the block registers rf_we=1, rf_addr=addr, rf_data=data.
- Write accepted with addr == 0: the request is consumed (ready honoured) but rf_we=0. `prio` still updates.
- No transfer: rf_we=0. rf_addr and rf_data hold their last values.
- stall_cnt increments by 1 in each cycle where (a_valid && !a_ready) || (m_valid && !m_ready). This includes cycles stalled by hold. The counter saturates at 2^CNT_W-1. Two stalled requesters in one cycle count as 1.
- Both requesters valid with the same addr: the round-robin order decides. The later-granted value lands last and therefore wins in the register file.
- Requesters must hold valid, addr and data stable until the transfer completes.

## Timing
- Reset (rst low, asynchronous): rf_we=0, rf_addr=0, rf_data=0, stall_cnt=0, prio=0, r1_fwd=r2_fwd=0 via rf_r*.
- Reset asserted mid-operation clears the registered write immediately. Any pending request is lost.
- Latency: a request accepted at edge N drives rf_we during cycle N..N+1. The register bank writes it at edge N+1. Throughput is one write per cycle.
- hold rising: ready drops in the same cycle. An already registered write still completes.

## Configuration
- FORWARD_EN defined:
  - r1_fwd = (rf_we && rf_addr!=0 && rf_addr==rd_addr1) ? rf_data : rf_r1. r2_fwd is built the same way.
  - The bypass is purely combinational, with zero added latency.
- FORWARD_EN undefined: the ports rd_addr*, rf_r* and r*_fwd are absent. The read path uses the register bank outputs directly.

## Structure
- Package `reg_wr_pkg` holds:
  - DATA_W, ADDR_W and CNT_W defaults
  - PRIO_A=0, PRIO_M=1
  - the REG_ZERO=0 address constant
- Sub-module `rr_arb2` holds the 2-way round-robin grant logic and the `prio` register. Its inputs are req[1:0] and hold. Its outputs are gnt[1:0], and `prio` updates internally.
- The top level holds the output register, x0 filter, stall counter and the FORWARD_EN bypass.

## Test plan
- Reset, then A alone writes x5=0x0000_00AA → a_ready=1; one cycle later rf_we=1, rf_addr=5, rf_data=0xAA; the bank reads back 0xAA.
- A and M valid together for 4 cycles with distinct addresses → grants alternate A, M, A, M (prio starts 0); stall_cnt=4.
- A writes x0=0xFFFF_FFFF → accepted with a_ready=1, rf_we stays 0, a read of x0 returns 0.
- hold=1 for 3 cycles with m_valid=1 → m_ready=0 and rf_we=0 for 3 cycles, stall_cnt=3; after hold drops, M is granted.
- rst pulled low in the cycle after a grant → rf_we drops asynchronously; stall_cnt=0 and prio=0 after release.
- With FORWARD_EN: write x7=0x1234_5678 while rd_addr1=7 and rf_r1=0 → r1_fwd=0x1234_5678 during the write cycle, and equals the bank value afterwards.
